// File: rtl/box_fill_engine.sv
// Rasters a solid or outline rectangle into a valid/ready framebuffer write port.
// Optional abort input is compiled in when BOX_FILL_ABORT_EN is defined.
module box_fill_engine #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 7,
  parameter int unsigned COL_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mode,
  input  logic [X_W-1:0]   x_left,
  input  logic [X_W-1:0]   x_right,
  input  logic [Y_W-1:0]   y_top,
  input  logic [Y_W-1:0]   y_bottom,
  input  logic [COL_W-1:0] colour,
  input  logic             wr_ready,
`ifdef BOX_FILL_ABORT_EN
  input  logic             abort,
`endif
  output logic             wr_en,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] col_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [X_W-1:0]     xl_q, xl_d;
  logic [X_W-1:0]     xr_q, xr_d;
  logic [Y_W-1:0]     yt_q, yt_d;
  logic [Y_W-1:0]     yb_q, yb_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               wr_en_q, wr_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               abort_req;
  logic               accept;
  logic               last_pix;
  logic               row_end;
  logic               interior_row;
  logic [X_W-1:0]     xl_n, xr_n;
  logic [Y_W-1:0]     yt_n, yb_n;

`ifdef BOX_FILL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Normalised corners of the incoming request.
  assign xl_n = (x_left <= x_right) ? x_left : x_right;
  assign xr_n = (x_left <= x_right) ? x_right : x_left;
  assign yt_n = (y_top <= y_bottom) ? y_top : y_bottom;
  assign yb_n = (y_top <= y_bottom) ? y_bottom : y_top;

  assign accept       = wr_en_q & wr_ready;
  assign row_end      = (x_q == xr_q);
  assign last_pix     = row_end && (y_q == yb_q);
  assign interior_row = (y_q != yt_q) && (y_q != yb_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    xl_d    = xl_q;
    xr_d    = xr_q;
    yt_d    = yt_q;
    yb_d    = yb_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    wr_en_d = wr_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          xl_d    = xl_n;
          xr_d    = xr_n;
          yt_d    = yt_n;
          yb_d    = yb_n;
          x_d     = xl_n;
          y_d     = yt_n;
          col_d   = colour;
          wr_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        // A write accepted on the aborting edge has already landed; just stop issuing.
        if (abort_req || (accept && last_pix)) begin
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (accept) begin
          if (row_end) begin
            x_d = xl_q;
            y_d = y_q + 1'b1;
          end else if (mode_q && interior_row) begin
            // Outline interior rows only touch the two edge columns.
            x_d = xr_q;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      xl_q    <= '0;
      xr_q    <= '0;
      yt_q    <= '0;
      yb_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
      yt_q    <= yt_d;
      yb_q    <= yb_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign x_out   = x_q;
  assign y_out   = y_q;
  assign col_out = col_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_box_fill_engine.sv
// Directed and randomised boxes checked against a pixel-list reference model.
module tb_box_fill_engine;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  logic             clk;
  logic             resetn;
  logic             start;
  logic             mode;
  logic [X_W-1:0]   x_left;
  logic [X_W-1:0]   x_right;
  logic [Y_W-1:0]   y_top;
  logic [Y_W-1:0]   y_bottom;
  logic [COL_W-1:0] colour;
  logic             wr_ready;
`ifdef BOX_FILL_ABORT_EN
  logic             abort;
`endif
  logic             wr_en;
  logic [X_W-1:0]   x_out;
  logic [Y_W-1:0]   y_out;
  logic [COL_W-1:0] col_out;
  logic             busy;
  logic             done;

  int vectors;
  int miscompares;

  box_fill_engine #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .COL_W(COL_W)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .mode    (mode),
    .x_left  (x_left),
    .x_right (x_right),
    .y_top   (y_top),
    .y_bottom(y_bottom),
    .colour  (colour),
    .wr_ready(wr_ready),
`ifdef BOX_FILL_ABORT_EN
    .abort   (abort),
`endif
    .wr_en   (wr_en),
    .x_out   (x_out),
    .y_out   (y_out),
    .col_out (col_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_x"}, 32'(x_out), 0);
    check({tag, "_y"}, 32'(y_out), 0);
    check({tag, "_col"}, 32'(col_out), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // rdy_mode: 0 always ready, 1 ready on even cycles only, 2 random.
  task automatic run_box(input bit md, input int xa, input int xb, input int ya, input int yb,
                         input int col, input int rdy_mode, input bit extra_start);
    int qx[$];
    int qy[$];
    int exl, exr, eyt, eyb, n, cyc, budget;
    bit rdy;
    exl = (xa < xb) ? xa : xb;
    exr = (xa < xb) ? xb : xa;
    eyt = (ya < yb) ? ya : yb;
    eyb = (ya < yb) ? yb : ya;
    for (int y = eyt; y <= eyb; y++) begin
      for (int x = exl; x <= exr; x++) begin
        if (!md || y == eyt || y == eyb || x == exl || x == exr) begin
          qx.push_back(x);
          qy.push_back(y);
        end
      end
    end
    n = qx.size();
    budget = 8 * n + 20;

    mode     = md;
    x_left   = xa[X_W-1:0];
    x_right  = xb[X_W-1:0];
    y_top    = ya[Y_W-1:0];
    y_bottom = yb[Y_W-1:0];
    colour   = col[COL_W-1:0];
    start    = 1'b1;
    step();
    start    = 1'b0;
    mode     = ~md;
    colour   = ~colour;
    cyc      = 1;
    rdy      = 1'b1;

    while (qx.size() > 0 && cyc < budget) begin
      check("wr_en", 32'(wr_en), 1);
      check("x_out", 32'(x_out), qx[0]);
      check("y_out", 32'(y_out), qy[0]);
      check("col_out", 32'(col_out), col[COL_W-1:0]);
      check("busy", 32'(busy), 1);
      check("done_early", 32'(done), 0);
      if (extra_start && cyc == 1) begin
        start    = 1'b1;
        x_left   = 8'd10;
        x_right  = 8'd12;
        y_top    = 7'd10;
        y_bottom = 7'd12;
      end else begin
        start = 1'b0;
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      wr_ready = rdy;
      step();
      if (rdy) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
      end
      cyc++;
    end
    start = 1'b0;
    check("pixels_left", 32'(qx.size()), 0);
    if (qx.size() > 0) begin
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      step();
    end else begin
      check("done_pulse", 32'(done), 1);
      check("wr_en_in_done", 32'(wr_en), 0);
      check("busy_in_done", 32'(busy), 0);
      if (rdy_mode == 0) check("done_cycle", 32'(cyc), 32'(n + 1));
      step();
      check("done_cleared", 32'(done), 0);
      check("wr_en_idle", 32'(wr_en), 0);
      check("busy_idle", 32'(busy), 0);
    end
    wr_ready = 1'b0;
  endtask

  initial begin
    int xa, xb, ya, yb, t;
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    start       = 1'b0;
    mode        = 1'b0;
    x_left      = '0;
    x_right     = '0;
    y_top       = '0;
    y_bottom    = '0;
    colour      = '0;
    wr_ready    = 1'b0;
`ifdef BOX_FILL_ABORT_EN
    abort       = 1'b0;
`endif
    #12;
    check_idle_outputs("reset");
    resetn = 1'b1;
    step();
    check_idle_outputs("post_reset");

    run_box(1'b0, 3, 4, 4, 5, 5, 0, 1'b0);
    run_box(1'b0, 3, 4, 4, 5, 5, 1, 1'b0);
    run_box(1'b1, 0, 3, 0, 2, 2, 0, 1'b0);
    run_box(1'b0, 6, 5, 2, 1, 7, 0, 1'b0);
    run_box(1'b0, 255, 255, 127, 127, 3, 0, 1'b1);
    run_box(1'b1, 250, 255, 120, 127, 6, 2, 1'b0);
    run_box(1'b1, 9, 9, 3, 8, 1, 2, 1'b0);
    run_box(1'b1, 2, 9, 5, 5, 4, 0, 1'b0);

    // Reset mid-box in cycle 3 abandons the box.
    mode     = 1'b0;
    x_left   = 8'd3;
    x_right  = 8'd4;
    y_top    = 7'd4;
    y_bottom = 7'd5;
    colour   = 3'd5;
    wr_ready = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    resetn = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    step();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_done_after_reset", 32'(done), 0);
      check("no_wr_after_reset", 32'(wr_en), 0);
    end

`ifdef BOX_FILL_ABORT_EN
    start = 1'b1;
    step();
    start = 1'b0;
    check("abort_px1_x", 32'(x_out), 3);
    check("abort_px1_y", 32'(y_out), 4);
    step();
    check("abort_px2_x", 32'(x_out), 4);
    check("abort_px2_y", 32'(y_out), 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_done", 32'(done), 1);
    check("abort_wr_en", 32'(wr_en), 0);
    check("abort_busy", 32'(busy), 0);
    step();
    check("abort_done_clear", 32'(done), 0);
    check("abort_idle_wr_en", 32'(wr_en), 0);
    wr_ready = 1'b0;
`endif

    for (int k = 0; k < 20; k++) begin
      xa = $urandom_range(0, 255);
      ya = $urandom_range(0, 127);
      xb = xa + $urandom_range(0, 12);
      yb = ya + $urandom_range(0, 6);
      if (xb > 255) xb = 255;
      if (yb > 127) yb = 127;
      if ($urandom_range(0, 1) == 1) begin
        t = xa; xa = xb; xb = t;
      end
      if ($urandom_range(0, 1) == 1) begin
        t = ya; ya = yb; yb = t;
      end
      run_box(1'($urandom_range(0, 1)), xa, xb, ya, yb, $urandom_range(0, 7),
              (k % 3 == 0) ? 0 : 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
